sb_tx_arbiter: RTL
==================

Name: sb_tx_arbiter

Overview:
Shares the single sideband TX serializer between the link-training requesters (SBINIT, MBINIT, MBTRAIN, LINKINIT substate engines inside the LTSM).
- Arbitrates round-robin and holds the winning 64-bit SB message until the serializer accepts it.
- Waits for the serializer to report completion, then enforces a minimum inter-packet idle gap on the SB lane.
- Runs in the SB clock domain (clk_100MHz) between the LTSM substate logic and the SB serializer.

Parameters:
N_REQ, 4, number of requesters (≥2)
MSG_W, 64, sideband message width in bits
GAP_CYC, 4, idle cycles enforced after each completed message (0 = no gap)
TIMEOUT_CYC, 1024, max cycles waiting for ser_done_i before abandoning the message

Ports:
clk_100MHz  input  1  sideband clock; the only clock
reset_n  input  1  asynchronous active-low reset
flush_i  input  1  abort pending, not-yet-accepted message (LTSM entering RESET/TRAINERROR)
req_valid_i  input  N_REQ  per-requester message valid
req_msg_i  input  N_REQ*MSG_W  per-requester message; requester i at bits [i*MSG_W +: MSG_W]
req_ready_o  output  N_REQ  one-hot accept; transfer when req_valid_i[i] & req_ready_o[i]
ser_valid_o  output  1  message available to serializer
ser_msg_o  output  MSG_W  message to serializer
ser_ready_i  input  1  serializer accepts when ser_valid_o & ser_ready_i
ser_done_i  input  1  one-cycle pulse: serializer finished shifting the message out
busy_o  output  1  state != IDLE
timeout_o  output  1  one-cycle pulse on ser_done_i timeout
msg_cnt_o  output  16  count of completed messages (done or timed out), wraps 0xFFFF→0

Behaviour:
- Reset (async, reset_n=0) forces:
  - state=IDLE, rr_ptr=N_REQ-1, hold register=0, counters=0.
  - all outputs 0.
  - Reset mid-operation discards the held message silently.
- States: IDLE, SEND, WAIT, GAP.
- IDLE:
  - Winner = first i with req_valid_i[i]=1, searching (rr_ptr+1) mod N_REQ upward, wrapping.
  - req_ready_o is combinational: one-hot(winner) when state==IDLE, any valid, flush_i=0; else 0.
  - On transfer edge: hold ← req_msg_i[winner], rr_ptr ← winner, state → SEND.
  - No valid, or flush_i=1: stay IDLE.
- SEND:
  - ser_valid_o=1 and ser_msg_o=hold, both driven from registered state/hold (no combinational path from req_*).
  - ser_ready_i=1 → WAIT, timeout counter cleared. This takes priority over a same-cycle flush_i.
  - flush_i=1 with ser_ready_i=0 → IDLE; message dropped, msg_cnt_o unchanged.
- WAIT:
  - ser_valid_o=0.
  - ser_done_i=1 → msg_cnt_o+1; if GAP_CYC>0 load gap counter with GAP_CYC-1 and go to GAP, else go to IDLE.
  - If the timeout counter reaches TIMEOUT_CYC-1 without done: timeout_o=1 for one cycle, msg_cnt_o+1, same exit as done.
  - Done and timeout in the same cycle: done wins, no timeout pulse.
  - flush_i is ignored.
- GAP:
  - Count down each cycle; at 0 → IDLE.
  - flush_i and ser_done_i are ignored; requests are not accepted.
- ser_done_i is sampled only in WAIT. A pulse in any other state, including the SEND accept cycle, is ignored.
- Latency:
  - Accept edge to ser_valid_o=1: 1 cycle.
  - Back-to-back messages: minimum period = 1 (IDLE) + SEND cycles + WAIT cycles + GAP_CYC.
- Fairness: a requester holding valid continuously is granted within N_REQ message slots.
- Protocol rules on requesters:
  - Requesters hold req_valid_i and req_msg_i stable until accepted. Dropping valid before acceptance is legal and simply removes the request from arbitration.
  - The arbiter never accepts a second message while busy_o=1.

Test Plan:
- Single request: reset, req_valid_i=4'b0001, msg=64'hDEAD_BEEF_0000_0001, ser_ready_i=1, ser_done_i 5 cycles later → req_ready_o=0001 for 1 cycle, ser_msg_o=64'hDEAD_BEEF_0000_0001 the next cycle, msg_cnt_o=1, then 4 GAP cycles with no accept before returning to IDLE.
- Round-robin: all four requesters valid continuously, ser_done_i 3 cycles after each accept → grant order 0,1,2,3,0,1; msg_cnt_o=6 after six dones; no requester starved.
- Serializer backpressure plus flush: ser_ready_i=0 for 10 cycles → ser_valid_o stays 1 with stable ser_msg_o. Then assert flush_i → IDLE next cycle, ser_valid_o=0, msg_cnt_o unchanged, req_ready_o=0 while flush_i=1.
- Flush/accept collision: flush_i and ser_ready_i both 1 in SEND → message accepted, state WAIT, completes normally on ser_done_i.
- Timeout: TIMEOUT_CYC=16, never pulse ser_done_i → timeout_o pulses exactly 16 cycles after the accept, msg_cnt_o increments, next request accepted after GAP. A late ser_done_i arriving in GAP is ignored.
- Async reset: assert reset_n=0 mid-WAIT (not on a clock edge) → all outputs 0 immediately. After release, requester 0 wins first, and msg_cnt_o wraps 0xFFFF→0x0000 after 65536 completions (preload via force).

Source files
------------

// File: rtl/sb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sb_tx_arbiter
// Purpose  : Round-robin arbiter that shares the sideband TX serializer
//            between the link-training substate engines. Holds the winning
//            message until the serializer accepts it, waits for completion
//            (with a timeout), then enforces an idle gap on the SB lane.
// Revision : 1.0 - initial release
// ============================================================================
module sb_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MSG_W       = 64,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk_100MHz,
  input  logic                   reset_n,
  input  logic                   flush_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*MSG_W-1:0] req_msg_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic                   ser_valid_o,
  output logic [MSG_W-1:0]       ser_msg_o,
  input  logic                   ser_ready_i,
  input  logic                   ser_done_i,
  output logic                   busy_o,
  output logic                   timeout_o,
  output logic [15:0]            msg_cnt_o
);

  // Counter widths; never below one bit so degenerate parameter values work.
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  // Terminal timeout count and gap-counter reload value.
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  state_e             state_q,   state_d;
  logic [PTR_W-1:0]   rr_ptr_q,  rr_ptr_d;
  logic [MSG_W-1:0]   hold_q,    hold_d;
  logic [TO_W-1:0]    to_cnt_q,  to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [15:0]        msg_cnt_q, msg_cnt_d;
  logic               timeout_q, timeout_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [N_REQ-1:0]   grant;
  logic [MSG_W-1:0]   win_msg;
  logic               complete;

  // Round-robin search: first valid requester starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!win_found && req_valid_i[(int'(rr_ptr_q) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
  end

  // One-hot accept, offered only in IDLE and never while flushing or in reset.
  always_comb begin
    grant = '0;
    if ((state_q == ST_IDLE) && win_found && !flush_i && reset_n) begin
      grant[win_idx] = 1'b1;
    end
  end

  assign win_msg = req_msg_i[int'(win_idx)*MSG_W +: MSG_W];

  // A message finishes on the done pulse, or when the timeout count expires.
  assign complete = ser_done_i || (to_cnt_q == TO_LAST);

  // Next-state logic; every register defaults to holding its value.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    msg_cnt_d = msg_cnt_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          hold_d   = win_msg;
          rr_ptr_d = win_idx;
          state_d  = ST_SEND;
        end
      end

      ST_SEND: begin
        // Serializer acceptance beats a simultaneous flush.
        if (ser_ready_i) begin
          to_cnt_d = '0;
          state_d  = ST_WAIT;
        end else if (flush_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (complete) begin
          msg_cnt_d = msg_cnt_q + 16'd1;
          // A done pulse on the final count is a normal completion.
          timeout_d = !ser_done_i;
          if (GAP_CYC > 0) begin
            gap_cnt_d = GAP_LOAD;
            state_d   = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any held message.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= PTR_W'(N_REQ - 1);
      hold_q    <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      msg_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      msg_cnt_q <= msg_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Serializer side is driven purely from registers.
  assign req_ready_o = grant;
  assign ser_valid_o = (state_q == ST_SEND);
  assign ser_msg_o   = hold_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign timeout_o   = timeout_q;
  assign msg_cnt_o   = msg_cnt_q;

endmodule
`default_nettype wire
